tengigeth_loop_frame_gen: RTL and testbench

TENGIGETH_LOOP_FRAME_GEN -- requirements
Module: tengigeth_loop_frame_gen

---
 rtl/tengigeth_loop_pkg.sv | 25 ++
 rtl/tengigeth_loop_beat_fmt.sv | 45 ++++
 rtl/tengigeth_loop_frame_gen.sv | 148 ++++++++++++++
 tb/tb_tengigeth_loop_frame_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tengigeth_loop_pkg.sv
// Shared constants, FSM state type and length clamp for the 10GbE loopback frame generator.
package tengigeth_loop_pkg;

    localparam logic [10:0] MIN_FRAME_LEN     = 11'd60;
    localparam logic [10:0] MAX_FRAME_LEN     = 11'd1514;
    localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h88B5;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        PAYLOAD,
        GAP
    } state_t;

    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        if (len < MIN_FRAME_LEN)
            return MIN_FRAME_LEN;
        else if (len > MAX_FRAME_LEN)
            return MAX_FRAME_LEN;
        else
            return len;
    endfunction

endpackage

// File: rtl/tengigeth_loop_beat_fmt.sv
// Combinational formatter: builds one 64-bit beat (header/payload lanes, tkeep, tlast)
// from the beat index and the frame parameters latched by the top.
module tengigeth_loop_beat_fmt
    import tengigeth_loop_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = DEFAULT_ETHERTYPE
) (
    input  logic [7:0]  beat_idx,
    input  logic [10:0] frame_len,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [7:0]  seq,
    output logic [63:0] data,
    output logic [7:0]  keep,
    output logic        last
);

    logic [111:0] header;
    logic [10:0]  len_round;
    logic [7:0]   last_idx;
    logic [2:0]   tail;
    logic [10:0]  pos;

    assign header    = {dst_mac, src_mac, ETHERTYPE};
    assign len_round = frame_len + 11'd7;
    assign last_idx  = len_round[10:3] - 8'd1;
    assign tail      = frame_len[2:0];
    assign last      = (beat_idx == last_idx);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        data = '0;
        keep = '0;
        pos  = '0;
        for (int n = 0; n < 8; n++) begin
            pos = {beat_idx, 3'b000} + 11'(n);
            if (pos < 11'd14)
                data[8*n +: 8] = header[8*(13 - int'(pos)) +: 8];
            else if (pos < frame_len)
                data[8*n +: 8] = seq + 8'(pos - 11'd14);
            keep[n] = !last || (tail == 3'd0) || (3'(n) < tail);
        end
    end

endmodule

// File: rtl/tengigeth_loop_frame_gen.sv
// 10GbE loopback test frame generator driving a 64-bit AXI4-Stream TX port.
// Optional statistics counters are enabled with macro TENGIGETH_LOOP_GEN_STATS_EN.
module tengigeth_loop_frame_gen
    import tengigeth_loop_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter logic [15:0] ETHERTYPE  = DEFAULT_ETHERTYPE
) (
    input  logic        piEthCoreClk,
    input  logic        piEthCoreResetDone,
    input  logic        piStart,
    input  logic        piStop,
    input  logic [47:0] piDstMac,
    input  logic [47:0] piSrcMac,
    input  logic [10:0] piFrameLen,
    input  logic [15:0] piFrameCount,
    output logic [63:0] po_Axis_tdata,
    output logic [7:0]  po_Axis_tkeep,
    output logic        po_Axis_tlast,
    output logic        po_Axis_tvalid,
    input  logic        pi_Axis_tready,
    output logic        poBusy,
    output logic        poDone,
    output logic [31:0] poFrameCnt,
    output logic [47:0] poByteCnt
);

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [47:0] dst_q, src_q;
    logic [10:0] len_q;
    logic [15:0] count_q, seq_q, gap_q;
    logic [7:0]  beat_q;
    logic        stop_q, done_q;

    logic [63:0] fmt_data;
    logic [7:0]  fmt_keep;
    logic        fmt_last;
    logic        valid, fire, frame_end, last_frame, finish;

    tengigeth_loop_beat_fmt #(.ETHERTYPE(ETHERTYPE)) u_beat_fmt (
        .beat_idx  (beat_q),
        .frame_len (len_q),
        .dst_mac   (dst_q),
        .src_mac   (src_q),
        .seq       (seq_q[7:0]),
        .data      (fmt_data),
        .keep      (fmt_keep),
        .last      (fmt_last)
    );

    assign valid      = (state_q == HDR0) || (state_q == HDR1) || (state_q == PAYLOAD);
    assign fire       = valid && pi_Axis_tready;
    assign frame_end  = fire && fmt_last;
    assign last_frame = (count_q != 16'd0) && (seq_q + 16'd1 == count_q);
    // A stop arriving on the deciding cycle itself still ends the burst.
    assign finish     = stop_q || piStop || last_frame;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (piStart) state_d = HDR0;
            HDR0:    if (fire) state_d = HDR1;
            HDR1:    if (fire) state_d = PAYLOAD;
            PAYLOAD: if (frame_end) begin
                if (GAP_CYCLES > 0)
                    state_d = GAP;
                else
                    state_d = finish ? IDLE : HDR0;
            end
            GAP:     if (gap_q == GAP_LAST) state_d = finish ? IDLE : HDR0;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge piEthCoreClk or posedge piEthCoreResetDone) begin
        if (piEthCoreResetDone) begin
            state_q <= IDLE;
            dst_q   <= '0;
            src_q   <= '0;
            len_q   <= MIN_FRAME_LEN;
            count_q <= '0;
            seq_q   <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q != IDLE) && (state_d == IDLE);
            gap_q   <= (state_q == GAP) ? gap_q + 16'd1 : 16'd0;

            if (state_q == IDLE)
                stop_q <= 1'b0;
            else if (piStop)
                stop_q <= 1'b1;

            if (state_q == IDLE && piStart) begin
                dst_q   <= piDstMac;
                src_q   <= piSrcMac;
                len_q   <= clamp_len(piFrameLen);
                count_q <= piFrameCount;
                seq_q   <= '0;
                beat_q  <= '0;
            end

            if (fire)
                beat_q <= beat_q + 8'd1;

            // Next frame of the same burst: overrides the beat increment above.
            if (state_q != IDLE && state_d == HDR0) begin
                seq_q  <= seq_q + 16'd1;
                beat_q <= '0;
            end
        end
    end

    assign po_Axis_tvalid = valid;
    assign po_Axis_tdata  = valid ? fmt_data : 64'd0;
    assign po_Axis_tkeep  = valid ? fmt_keep : 8'd0;
    assign po_Axis_tlast  = valid && fmt_last;
    assign poBusy         = (state_q != IDLE);
    assign poDone         = done_q;

`ifdef TENGIGETH_LOOP_GEN_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [47:0] byte_cnt_q;

    always_ff @(posedge piEthCoreClk or posedge piEthCoreResetDone) begin
        if (piEthCoreResetDone) begin
            frame_cnt_q <= '0;
            byte_cnt_q  <= '0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
            byte_cnt_q  <= byte_cnt_q + 48'(len_q);
        end
    end

    assign poFrameCnt = frame_cnt_q;
    assign poByteCnt  = byte_cnt_q;
`else
    assign poFrameCnt = '0;
    assign poByteCnt  = '0;
`endif

endmodule

// File: tb/tb_tengigeth_loop_frame_gen.sv
// Scoreboard bench for tengigeth_loop_frame_gen: a byte-level frame model pushes expected
// beats at stimulus time; a negedge monitor compares every offered beat against the queue head.
module tb_tengigeth_loop_frame_gen;

    localparam int          GAP   = 1;
    localparam logic [15:0] ETYPE = 16'h88B5;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [47:0] da = '0, sa = '0;
    logic [10:0] flen = '0;
    logic [15:0] fcnt = '0;
    logic        tready = 1'b1;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast, tvalid, busy, done;
    logic [31:0] frame_cnt;
    logic [47:0] byte_cnt;

    beat_t exp_q[$];
    int    n_checks = 0, n_errors = 0;
    int    cyc = 0, last_cyc = 0, frames_seen = 0;
    int    gap_run = 0;
    bit    gap_pending = 0;
    int    rdy_mode = 0;

    tengigeth_loop_frame_gen #(.GAP_CYCLES(GAP), .ETHERTYPE(ETYPE)) dut (
        .piEthCoreClk       (clk),
        .piEthCoreResetDone (rst),
        .piStart            (start),
        .piStop             (stop),
        .piDstMac           (da),
        .piSrcMac           (sa),
        .piFrameLen         (flen),
        .piFrameCount       (fcnt),
        .po_Axis_tdata      (tdata),
        .po_Axis_tkeep      (tkeep),
        .po_Axis_tlast      (tlast),
        .po_Axis_tvalid     (tvalid),
        .pi_Axis_tready     (tready),
        .poBusy             (busy),
        .poDone             (done),
        .poFrameCnt         (frame_cnt),
        .poByteCnt          (byte_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int len);
        return (len < 60) ? 60 : (len > 1514) ? 1514 : len;
    endfunction

    function automatic logic [63:0] kmask(input logic [7:0] k);
        logic [63:0] m = '0;
        for (int n = 0; n < 8; n++) m[8*n +: 8] = {8{k[n]}};
        return m;
    endfunction

    // Frame model: DA then SA most-significant byte first, EtherType high byte first, counting payload.
    task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input int len_raw,
                              input logic [15:0] seq);
        int    len = clamp(len_raw);
        int    nb  = (len + 7) / 8;
        beat_t bt;
        logic [7:0] v;
        for (int b = 0; b < nb; b++) begin
            bt = '0;
            for (int n = 0; n < 8; n++) begin
                int p = b * 8 + n;
                if (p < 6)        v = d[8*(5 - p) +: 8];
                else if (p < 12)  v = s[8*(11 - p) +: 8];
                else if (p == 12) v = ETYPE[15:8];
                else if (p == 13) v = ETYPE[7:0];
                else if (p < len) v = 8'(seq[7:0] + 8'(p - 14));
                else              v = 8'h00;
                bt.data[8*n +: 8] = v;
                bt.keep[n]        = (p < len);
            end
            bt.last = (b == nb - 1);
            exp_q.push_back(bt);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (tvalid) begin
                if (gap_pending) begin
                    check("gap_len", 64'(gap_run), 64'(GAP));
                    gap_pending = 0;
                end
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 64'(tvalid), 64'd0);
                end else begin
                    e = exp_q[0];
                    check("tdata", tdata & kmask(e.keep), e.data & kmask(e.keep));
                    check("tkeep", 64'(tkeep), 64'(e.keep));
                    check("tlast", 64'(tlast), 64'(e.last));
                    if (tready) begin
                        e = exp_q.pop_front();
                        if (tlast) begin
                            frames_seen++;
                            last_cyc    = cyc;
                            gap_pending = 1;
                            gap_run     = 0;
                        end
                    end
                end
            end else if (busy && gap_pending) begin
                gap_run++;
            end else if (!busy) begin
                gap_pending = 0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        gap_pending = 0;
        frames_seen = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [47:0] d, input logic [47:0] s, input int len,
                               input int count);
        @(posedge clk);
        #1;
        da = d; sa = s; flen = 11'(len); fcnt = 16'(count); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("first_valid", 64'(tvalid), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_done_latency"}, 64'(cyc - last_cyc), 64'(GAP + 1));
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic check_stats(input string tag, input int frames, input int bytes);
`ifdef TENGIGETH_LOOP_GEN_STATS_EN
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(frames));
        check({tag, "_byte_cnt"}, 64'(byte_cnt), 64'(bytes));
`else
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(frames * 0));
        check({tag, "_byte_cnt"}, 64'(byte_cnt), 64'(bytes * 0));
`endif
    endtask

    task automatic run_burst(input string tag, input int len, input int count, input int mode,
                             input bit poke_start);
        do_reset();
        rdy_mode = mode;
        for (int i = 0; i < count; i++) push_frame(48'h0A0B0C0D0E0F, 48'h112233445566, len, 16'(i));
        pulse_start(48'h0A0B0C0D0E0F, 48'h112233445566, len, count);
        if (poke_start) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(tag);
        check({tag, "_frames"}, 64'(frames_seen), 64'(count));
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check_stats(tag, count, count * clamp(len));
    endtask

    initial begin
        int k;
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tkeep_tlast", {55'd0, tkeep, tlast}, 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        check_stats("rst", 0, 0);

        run_burst("len64", 64, 1, 0, 0);
        run_burst("len61", 61, 1, 0, 0);
        run_burst("len20", 20, 1, 0, 0);
        run_burst("len2000", 2000, 1, 2, 0);
        run_burst("cnt3_toggle", 64, 3, 1, 1);

        // Continuous burst stopped during the second frame.
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) push_frame(48'hDEADBEEF0001, 48'h020304050607, 64, 16'(i));
        pulse_start(48'hDEADBEEF0001, 48'h020304050607, 64, 0);
        k = 0;
        while (frames_seen < 1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("stop_first_frame", 64'(frames_seen), 64'd1);
        repeat (3) @(negedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        wait_done("stop");
        check("stop_frames", 64'(frames_seen), 64'd2);
        check("stop_leftover", 64'(exp_q.size()), 64'd8);
        check_stats("stop", 2, 128);
        exp_q.delete();

        // Reset in the middle of the payload.
        do_reset();
        rdy_mode = 0;
        push_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 200, 16'd0);
        pulse_start(48'h0A0B0C0D0E0F, 48'h112233445566, 200, 1);
        k = 0;
        while (exp_q.size() > 20 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reached", 64'(exp_q.size() <= 20), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_tvalid", 64'(tvalid), 64'd0);
        check("rst_mid_tdata", tdata, 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check_stats("rst_mid", 0, 0);
        exp_q.delete();
        gap_pending = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tvalid || busy) seen++;
        end
        check("rst_mid_no_resume", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
